// File: rtl/weight_fetch_sched_if.sv
// Bundle of all weight_fetch_sched control, host-write, output-stream and memory signals.
// The slave modport is the scheduler's view; master is the surrounding system.
interface weight_fetch_sched_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [31:0]      base_addr;
    logic [15:0]      num_words;
    logic             busy;
    logic             done;

    logic             host_wr_req;
    logic [31:0]      host_wr_addr;
    logic [WIDTH-1:0] host_wr_data;
    logic             host_wr_gnt;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    logic             mem_write_en;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0] mem_data_out;

    modport slave (
        input  start, base_addr, num_words,
        input  host_wr_req, host_wr_addr, host_wr_data,
        input  out_ready, mem_data_out,
        output busy, done, host_wr_gnt,
        output out_valid, out_data, out_last,
        output mem_write_en, mem_addr, mem_data_in
    );

    modport master (
        output start, base_addr, num_words,
        output host_wr_req, host_wr_addr, host_wr_data,
        output out_ready, mem_data_out,
        input  busy, done, host_wr_gnt,
        input  out_valid, out_data, out_last,
        input  mem_write_en, mem_addr, mem_data_in
    );
endinterface

// File: rtl/weight_fetch_sched.sv
// Burst weight fetcher: streams num_words memory words through a 2-entry FIFO, host writes take priority.
// Optional macro WFS_STALL_CNT_EN adds the stall_cnt output (cycles busy with a stalled valid word).
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing reads, one per unblocked cycle
//   DRAIN | all reads issued, waiting for the last word to transfer
//   DONE  | one-cycle completion, done=1
module weight_fetch_sched #(
    parameter int WIDTH  = 64,
    parameter int LENGTH = 4096
) (
    input  logic                clk,
    input  logic                rst,
    weight_fetch_sched_if.slave bus_if
`ifdef WFS_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int AW = $clog2(LENGTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [15:0]      rd_rem_q, rd_rem_d;
    logic             infl_q, infl_last_q;

    logic [WIDTH-1:0] fifo_data_q [2];
    logic [1:0]       fifo_last_q;
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       cnt_q;

    logic             host_gnt;
    logic             start_acc;
    logic             out_valid;
    logic             pop;
    logic             push;
    logic             rd_issue;
    logic             rd_is_last;
    logic [2:0]       occ_after;
    logic             unused_base_hi;

    assign unused_base_hi = ^bus_if.base_addr[31:AW];

    assign host_gnt   = bus_if.host_wr_req & ~rst;
    assign start_acc  = (state_q == S_IDLE) & bus_if.start;
    assign out_valid  = (cnt_q != 2'd0);
    assign pop        = out_valid & bus_if.out_ready;
    assign push       = infl_q;
    assign rd_is_last = (rd_rem_q == 16'd1);

    // The word leaving the FIFO this cycle frees its slot, which keeps a full-rate stream going.
    assign occ_after = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, infl_q};
    assign rd_issue  = (state_q == S_FETCH) & ~bus_if.host_wr_req & (occ_after < 3'd2);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_rem_d = rd_rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    if (bus_if.num_words != 16'd0) begin
                        state_d  = S_FETCH;
                        addr_d   = bus_if.base_addr[AW-1:0];
                        rd_rem_d = bus_if.num_words;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (rd_issue) begin
                    addr_d   = addr_q + 1'b1;
                    rd_rem_d = rd_rem_q - 16'd1;
                    if (rd_is_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rd_rem_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_rem_q <= rd_rem_d;
        end
    end

    // Read data arrives one cycle after issue; the last-word tag travels with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= rd_issue;
            infl_last_q <= rd_issue & rd_is_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus_if.mem_data_out;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus_if.busy         = (state_q == S_FETCH) | (state_q == S_DRAIN);
    assign bus_if.done         = (state_q == S_DONE);
    assign bus_if.host_wr_gnt  = host_gnt;
    assign bus_if.mem_write_en = host_gnt;
    assign bus_if.mem_data_in  = host_gnt ? bus_if.host_wr_data : '0;
    assign bus_if.mem_addr     = host_gnt ? bus_if.host_wr_addr :
                                 rd_issue ? 32'(addr_q)         : 32'd0;
    assign bus_if.out_valid    = out_valid;
    assign bus_if.out_data     = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus_if.out_last     = out_valid & fifo_last_q[rd_ptr_q];

`ifdef WFS_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (bus_if.busy && out_valid && !bus_if.out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Directed bench for weight_fetch_sched: bursts, wrap, stalls, host writes, zero length, mid-burst reset.
module tb_weight_fetch_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_fetch_sched_if #(.WIDTH(64)) bus();

`ifdef WFS_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    weight_fetch_sched #(.WIDTH(64), .LENGTH(4096)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
`ifdef WFS_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int   checks     = 0;
    int   failures   = 0;
    logic a5_written = 1'b0;
    logic mem_clr    = 1'b1;

    logic [4095:0] wr_vld;
    logic [63:0]   wr_mem [4096];

    function automatic logic [63:0] init_word(input logic [11:0] a);
        return {20'hCAFE0, a, 20'h0F0F0, ~a};
    endfunction

    function automatic logic [63:0] exp_word(input logic [11:0] a);
        if (a == 12'd100 && a5_written) return 64'h0000_0000_0000_A5A5;
        return init_word(a);
    endfunction

    // Synchronous memory: write wins, otherwise read data returns one cycle later.
    always @(posedge clk) begin
        if (mem_clr) begin
            wr_vld <= '0;
        end else if (bus.mem_write_en) begin
            wr_vld[bus.mem_addr[11:0]] <= 1'b1;
            wr_mem[bus.mem_addr[11:0]] <= bus.mem_data_in;
        end
        bus.mem_data_out <= wr_vld[bus.mem_addr[11:0]] ? wr_mem[bus.mem_addr[11:0]]
                                                       : init_word(bus.mem_addr[11:0]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ready_mode 0: always ready; 1: ready pattern 1,0,0,1 repeating.
    task automatic run_burst(input string name, input logic [31:0] base, input int n,
                             input int ready_mode, input int host_at, input int ign_at,
                             input int exp_done);
        int          s       = 0;
        int          got     = 0;
        int          first_v = -1;
        int          done_s  = -1;
        int          grants  = 0;
        int          stalls  = 0;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_d  = '0;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_words = 16'(n);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (done_s < 0 && s < 200) begin
            bus.out_ready   = (ready_mode == 0) ? 1'b1 : ((s % 4 == 0) || (s % 4 == 3));
            bus.host_wr_req = (host_at >= 0) && (s >= host_at) && (s < host_at + 3);
            bus.start       = (s == ign_at);
            if (s == ign_at) begin
                bus.base_addr = 32'd3000;
                bus.num_words = 16'd5;
            end
            #1;
            if (bus.host_wr_req) begin
                grants++;
                chk({name, "_gnt"},    64'(bus.host_wr_gnt),  64'd1);
                chk({name, "_wr_en"},  64'(bus.mem_write_en), 64'd1);
                chk({name, "_wr_adr"}, 64'(bus.mem_addr),     64'd100);
            end
            if (n == 0) chk({name, "_no_read"}, 64'(bus.mem_addr), 64'd0);
            if (prev_stall) begin
                chk({name, "_hold_v"}, 64'(bus.out_valid), 64'd1);
                chk({name, "_hold_d"}, bus.out_data, prev_d);
            end
            if (bus.out_valid && first_v < 0) first_v = s;
            if (bus.out_valid && bus.out_ready) begin
                chk({name, "_data"}, bus.out_data, exp_word(12'(base + 32'(got))));
                chk({name, "_last"}, 64'(bus.out_last), 64'(got == n - 1));
                got++;
            end
            if (bus.busy && bus.out_valid && !bus.out_ready) stalls++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            if (bus.done) done_s = s;
            @(negedge clk);
            s++;
        end
        bus.start       = 1'b0;
        bus.host_wr_req = 1'b0;
        bus.out_ready   = 1'b1;
        #1;
        chk({name, "_done_seen"}, 64'(done_s >= 0), 64'd1);
        chk({name, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({name, "_words"}, 64'(got), 64'(n));
        chk({name, "_first_v"}, 64'(first_v), 64'(n == 0 ? -1 : 2));
        if (exp_done >= 0) chk({name, "_done_cyc"}, 64'(done_s), 64'(exp_done));
        if (host_at >= 0) chk({name, "_grants"}, 64'(grants), 64'd3);
`ifdef WFS_STALL_CNT_EN
        chk({name, "_stall_cnt"}, 64'(stall_cnt), 64'(stalls));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start        = 1'b0;
        bus.base_addr    = '0;
        bus.num_words    = '0;
        bus.host_wr_req  = 1'b0;
        bus.host_wr_addr = 32'd100;
        bus.host_wr_data = 64'h0000_0000_0000_A5A5;
        bus.out_ready    = 1'b1;
        #1;
        chk("rst_busy",   64'(bus.busy),         64'd0);
        chk("rst_done",   64'(bus.done),         64'd0);
        chk("rst_valid",  64'(bus.out_valid),    64'd0);
        chk("rst_last",   64'(bus.out_last),     64'd0);
        chk("rst_wr_en",  64'(bus.mem_write_en), 64'd0);
        chk("rst_addr",   64'(bus.mem_addr),     64'd0);
        chk("rst_data",   bus.out_data,          64'd0);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        mem_clr = 1'b0;

        run_burst("seq16", 32'd0,    16, 0, -1, -1, 18);
        run_burst("wrap",  32'd4094,  4, 0, -1,  1,  6);
        run_burst("stall", 32'd200,   8, 1, -1, -1, -1);
        run_burst("host",  32'd0,    16, 0,  5, -1, 21);
        a5_written = 1'b1;
        chk("mem100_vld",  64'(wr_vld[100]), 64'd1);
        chk("mem100_data", wr_mem[100],      64'h0000_0000_0000_A5A5);
        run_burst("zero",  32'd50,    0, 0, -1, -1,  0);

        // Fill the FIFO with out_ready low, then reset asynchronously mid-cycle.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 32'd500;
        bus.num_words = 16'd8;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("full_valid", 64'(bus.out_valid), 64'd1);
        chk("full_head",  bus.out_data,       exp_word(12'd500));
        rst             = 1'b1;
        bus.host_wr_req = 1'b1;
        #1;
        chk("arst_busy",   64'(bus.busy),         64'd0);
        chk("arst_done",   64'(bus.done),         64'd0);
        chk("arst_valid",  64'(bus.out_valid),    64'd0);
        chk("arst_last",   64'(bus.out_last),     64'd0);
        chk("arst_gnt",    64'(bus.host_wr_gnt),  64'd0);
        chk("arst_wr_en",  64'(bus.mem_write_en), 64'd0);
        chk("arst_addr",   64'(bus.mem_addr),     64'd0);
        chk("arst_wdata",  bus.mem_data_in,       64'd0);
        chk("arst_data",   bus.out_data,          64'd0);
        @(negedge clk);
        rst             = 1'b0;
        bus.host_wr_req = 1'b0;
        bus.out_ready   = 1'b1;
        #1;
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

        run_burst("clean", 32'd96, 8, 0, -1, -1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
